led_scan_drv: RTL



---
 rtl/led_scan_drv_pkg.sv | 36 +++
 rtl/led_scan_drv_if.sv | 27 ++
 rtl/led_scan_tmr.sv | 71 +++++++
 rtl/led_scan_drv.sv | 93 +++++++++
 4 files changed

// File: rtl/led_scan_drv_pkg.sv
// Shared constants, phase encoding and LED index map for the LED matrix scanner.
// The index map is the single definition of LED k -> (row k/6, column k%6).
package led_scan_drv_pkg;

    localparam int C_LED_N  = 18;
    localparam int C_ROW_N  = 3;
    localparam int C_COL_N  = 6;
    localparam int C_ROW_W  = 2;
    localparam int C_COL_W  = 3;
    localparam int C_IDX_W  = 5;
    localparam int C_DUTY_W = 3;

    typedef enum logic [1:0] {
        PH_BLANK = 2'd0,
        PH_ON    = 2'd1,
        PH_OFF   = 2'd2
    } phase_e;

    // Ceiling log2, never below 1 so that a counter always has at least one bit.
    function automatic int f_log2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                r = i + 1;
            end
        end
        return (r < 1) ? 1 : r;
    endfunction

    function automatic logic [C_IDX_W-1:0] f_led_idx(input logic [C_ROW_W-1:0] row,
                                                     input logic [C_COL_W-1:0] col);
        return C_IDX_W'(row) * C_IDX_W'(C_COL_N) + C_IDX_W'(col);
    endfunction

endpackage

// File: rtl/led_scan_drv_if.sv
// Core-to-driver bundle: LED vector and brightness in, matrix drive and frame strobe out.
interface led_scan_drv_if;
    import led_scan_drv_pkg::*;

    logic [C_LED_N-1:0]  LEDs_ON_i;
    logic [C_DUTY_W-1:0] DUTY_i;
    logic [C_ROW_N-1:0]  ROWs_o;
    logic [C_COL_N-1:0]  XCOLs_o;
    logic                FRAME_o;

    modport master (
        output LEDs_ON_i,
        output DUTY_i,
        input  ROWs_o,
        input  XCOLs_o,
        input  FRAME_o
    );

    modport slave (
        input  LEDs_ON_i,
        input  DUTY_i,
        output ROWs_o,
        output XCOLs_o,
        output FRAME_o
    );

endinterface

// File: rtl/led_scan_tmr.sv
// Row-slot timer: slot counter, row index, frame-start strobe and blank/on/off decode.
module led_scan_tmr
    import led_scan_drv_pkg::*;
#(
    parameter int C_ROW_CK_N = 45_000,
    parameter int C_BLANK_N  = 1_350
) (
    input  logic                clk_i,
    input  logic                srst_i,
    input  logic [C_DUTY_W-1:0] duty_l_i,
    output logic                frm_start_o,
    output logic [C_ROW_W-1:0]  row_idx_o,
    output phase_e              phase_o
);

    localparam int C_ACT  = C_ROW_CK_N - C_BLANK_N;
    localparam int C_SLOT = C_ACT / 8;
    localparam int C_CW   = f_log2(C_ROW_CK_N);
    localparam int C_EW   = f_log2(C_ROW_CK_N + 1);

    if (C_ACT < 8) begin : g_illegal_window
        $error("led_scan_tmr: C_ROW_CK_N - C_BLANK_N must be at least 8");
    end

    logic [C_CW-1:0]    slot_ctr_q, slot_ctr_d;
    logic [C_ROW_W-1:0] row_idx_q, row_idx_d;
    logic [C_EW-1:0]    ctr_ext_s;
    logic [C_EW-1:0]    on_end_s;

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            slot_ctr_q <= '0;
            row_idx_q  <= '0;
        end else begin
            slot_ctr_q <= slot_ctr_d;
            row_idx_q  <= row_idx_d;
        end
    end

    always_comb begin
        slot_ctr_d = slot_ctr_q;
        row_idx_d  = row_idx_q;
        if (slot_ctr_q == C_CW'(C_ROW_CK_N - 1)) begin
            slot_ctr_d = '0;
            if (row_idx_q == C_ROW_W'(C_ROW_N - 1)) begin
                row_idx_d = '0;
            end else begin
                row_idx_d = row_idx_q + C_ROW_W'(1);
            end
        end else begin
            slot_ctr_d = slot_ctr_q + C_CW'(1);
        end
    end

    // The on window ends at blank + SLOT*(duty+1); the floor leftover falls into OFF.
    always_comb begin
        ctr_ext_s = C_EW'(slot_ctr_q);
        on_end_s  = C_EW'(C_BLANK_N) + C_EW'(C_SLOT) * (C_EW'(duty_l_i) + C_EW'(1));
        if (ctr_ext_s < C_EW'(C_BLANK_N)) begin
            phase_o = PH_BLANK;
        end else if (ctr_ext_s < on_end_s) begin
            phase_o = PH_ON;
        end else begin
            phase_o = PH_OFF;
        end
    end

    assign frm_start_o = (row_idx_q == '0) && (slot_ctr_q == '0);
    assign row_idx_o   = row_idx_q;

endmodule

// File: rtl/led_scan_drv.sv
// Time-multiplexed 3x6 LED matrix driver: per-frame snapshot, row blanking, 8-level PWM.
module led_scan_drv
    import led_scan_drv_pkg::*;
#(
    parameter int C_ROW_CK_N = 45_000,
    parameter int C_BLANK_N  = 1_350,
    parameter int C_ROW_N    = 3,
    parameter int C_COL_N    = 6
) (
    input  logic          CK_i,
    input  logic          SRST_i,
    led_scan_drv_if.slave bus_if
);

    if ((C_ROW_N != led_scan_drv_pkg::C_ROW_N) || (C_COL_N != led_scan_drv_pkg::C_COL_N)) begin : g_illegal_geometry
        $error("led_scan_drv: matrix geometry is fixed at 3 rows x 6 columns");
    end

    logic [led_scan_drv_pkg::C_LED_N-1:0] snap_q, snap_d, snap_eff_s;
    logic [C_DUTY_W-1:0]                  duty_l_q, duty_l_d, duty_eff_s;
    logic [led_scan_drv_pkg::C_ROW_N-1:0] rows_q, rows_d;
    logic [led_scan_drv_pkg::C_COL_N-1:0] xcols_q, xcols_d;
    logic                                 frame_q, frame_d;
    logic                                 frm_start_s;
    logic [C_ROW_W-1:0]                   row_idx_s;
    phase_e                               phase_s;

    led_scan_tmr #(
        .C_ROW_CK_N (C_ROW_CK_N),
        .C_BLANK_N  (C_BLANK_N)
    ) u_tmr (
        .clk_i       (CK_i),
        .srst_i      (SRST_i),
        .duty_l_i    (duty_eff_s),
        .frm_start_o (frm_start_s),
        .row_idx_o   (row_idx_s),
        .phase_o     (phase_s)
    );

    // On the frame-start cycle the fresh inputs are used directly so the whole frame is coherent.
    always_comb begin
        if (frm_start_s) begin
            snap_eff_s = bus_if.LEDs_ON_i;
            duty_eff_s = bus_if.DUTY_i;
        end else begin
            snap_eff_s = snap_q;
            duty_eff_s = duty_l_q;
        end
        snap_d  = snap_eff_s;
        duty_l_d = duty_eff_s;
        frame_d = frm_start_s;
    end

    always_comb begin
        rows_d  = '0;
        xcols_d = '1;
        if (phase_s == PH_ON) begin
            case (row_idx_s)
                2'd0:    rows_d = 3'b001;
                2'd1:    rows_d = 3'b010;
                2'd2:    rows_d = 3'b100;
                default: rows_d = 3'b000;
            endcase
            for (int c = 0; c < led_scan_drv_pkg::C_COL_N; c++) begin
                xcols_d[c] = ~snap_eff_s[f_led_idx(row_idx_s, C_COL_W'(c))];
            end
        end else begin
            rows_d  = '0;
            xcols_d = '1;
        end
    end

    always_ff @(posedge CK_i) begin
        if (SRST_i) begin
            snap_q   <= '0;
            duty_l_q <= '0;
            rows_q   <= '0;
            xcols_q  <= '1;
            frame_q  <= 1'b0;
        end else begin
            snap_q   <= snap_d;
            duty_l_q <= duty_l_d;
            rows_q   <= rows_d;
            xcols_q  <= xcols_d;
            frame_q  <= frame_d;
        end
    end

    assign bus_if.ROWs_o  = rows_q;
    assign bus_if.XCOLs_o = xcols_q;
    assign bus_if.FRAME_o = frame_q;

endmodule
